// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the chunked popcount sequencer.
package popcount_pkg;

  localparam int unsigned CHUNK_W        = 3;
  localparam int unsigned CHUNKS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Input word width for a given chunk count.
  function automatic int unsigned calc_w(input int unsigned chunks);
    return CHUNK_W * chunks;
  endfunction

  // Count width able to hold every value 0..W.
  function automatic int unsigned calc_cw(input int unsigned chunks);
    return $clog2(CHUNK_W * chunks + 1);
  endfunction

endpackage

// File: rtl/popcount3.sv
// Combinational population count of a 3-bit chunk.
module popcount3 (
  input  logic [2:0] bits,
  output logic [1:0] count
);

  assign count = 2'(bits[0]) + 2'(bits[1]) + 2'(bits[2]);

endmodule

// File: rtl/popcount_sequencer.sv
// Counts the 1 bits of an accepted word, one 3-bit chunk per cycle, with
// valid/ready handshakes on both sides and a synchronous abort.
module popcount_sequencer
  import popcount_pkg::*;
#(
  parameter  int unsigned CHUNKS = CHUNKS_DEFAULT,
  localparam int unsigned W      = calc_w(CHUNKS),
  localparam int unsigned CW     = calc_cw(CHUNKS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          busy
);

  localparam int unsigned    IW       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(CHUNKS - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [1:0]     chunk_count;

  logic           in_ready_d;
  logic           out_valid_d;
  logic           busy_d;
  logic [CW-1:0]  out_count_d;

  popcount3 u_popcount3 (
    .bits  (shift_q[CHUNK_W-1:0]),
    .count (chunk_count)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          shift_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      RUN: begin
        acc_d   = acc_q + CW'(chunk_count);
        shift_d = shift_q >> CHUNK_W;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over any handshake on the same edge.
    if (abort) begin
      state_d = IDLE;
      shift_d = '0;
      acc_d   = '0;
      idx_d   = '0;
    end

    // Outputs are registered from the next state so they track the FSM exactly.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    out_count_d = (state_d == DONE) ? acc_d : '0;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_count <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      out_count <= out_count_d;
    end
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Directed and randomized bench for popcount_sequencer with a bit-loop reference model.
module tb_popcount_sequencer;

  localparam int unsigned CHUNKS = 4;
  localparam int unsigned W      = 12;
  localparam int unsigned CW     = 4;

  logic          clk;
  logic          rst_n;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          busy;

  int checks   = 0;
  int errors   = 0;
  int hs_count = 0;
  int exp_hs   = 0;

  popcount_sequencer #(.CHUNKS(CHUNKS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output handshakes as seen by the consumer; an aborted edge is not a handshake.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && !abort) hs_count = hs_count + 1;
  end

  function automatic int ref_pop(input logic [W-1:0] word);
    int n = 0;
    for (int i = 0; i < int'(W); i++) n += int'(word[i]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_count"}, 32'(out_count), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Accept one word, hold the result for 'hold' cycles, then drain it.
  task automatic run_word(input logic [W-1:0] word, input int hold, input string tag);
    int exp;
    exp       = ref_pop(word);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = word;
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    check({tag, "_busy"},     32'(busy),     32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < int'(CHUNKS); i++) begin
      check({tag, "_run_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_run_count"}, 32'(out_count), 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      tick();
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_count"}, 32'(out_count), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_count"}, 32'(out_count), 32'(exp));
      check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_hs++;
    check_idle({tag, "_post"});
  endtask

  initial begin
    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check_idle("reset");
    rst_n = 1'b1;

    run_word(12'hFFF, 0, "all_ones");
    run_word(12'h000, 0, "zero");
    run_word(12'b101_010_110_001, 0, "mixed");
    run_word(12'hA5A, 10, "stall");

    // Abort on the second RUN cycle.
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_run");
    for (int i = 0; i < int'(CHUNKS) + 1; i++) begin
      check("abort_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    run_word(12'h007, 0, "after_abort");

    // Abort beats a simultaneous input handshake.
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    check_idle("abort_accept");

    // Asynchronous reset in the middle of RUN.
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    #2 rst_n = 1'b1;
    tick();
    run_word(12'h800, 0, "after_reset");

    // Abort together with out_ready in DONE discards the result.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 12'h0F0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < int'(CHUNKS); i++) tick();
    check("done_abort_valid", 32'(out_valid), 32'd1);
    check("done_abort_count", 32'(out_count), 32'd4);
    abort     = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("done_abort");

    for (int n = 0; n < 16; n++) begin
      run_word(W'($urandom), int'($urandom_range(0, 3)), "random");
    end

    check("handshakes", 32'(hs_count), 32'(exp_hs));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
